// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// voice_allocator : scans synchronised keys one per cycle, assigns held keys
//                   to voice slots (oldest voice stolen when full) and mixes
//                   the selected note samples into one registered word.
// Revision        : 1.0
// ============================================================================
module voice_allocator #(
    parameter int NKEYS   = 36,
    parameter int NVOICES = 4,
    parameter int W       = 16,
    parameter int KW      = 6,
    parameter int MW      = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NKEYS-1:0]      keys,
    input  logic [NKEYS*W-1:0]    note_bus,
    output logic [NVOICES-1:0]    voice_active,
    output logic [NVOICES*KW-1:0] voice_note,
    output logic [2:0]            voice_count,
    output logic [MW-1:0]         mix_out
);
    localparam int              AW           = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [AW-1:0]   C_AGE_OLDEST = AW'(NVOICES - 1);
    localparam logic [KW-1:0]   C_SCAN_LAST  = KW'(NKEYS - 1);
    localparam logic [KW:0]     C_NKEYS      = (KW+1)'(NKEYS);

    logic [NKEYS-1:0]   r_sync1;
    logic [NKEYS-1:0]   r_ks;
    logic [NKEYS-1:0]   r_lock;
    logic [NKEYS-1:0]   w_lock_nxt;
    logic [KW-1:0]      r_scan;
    logic [NVOICES-1:0] r_active;
    logic [NVOICES-1:0] w_active_nxt;
    logic [KW-1:0]      r_note     [NVOICES];
    logic [KW-1:0]      w_note_nxt [NVOICES];
    logic [AW-1:0]      r_age      [NVOICES];
    logic [AW-1:0]      w_age_nxt  [NVOICES];
    logic [2:0]         r_count;
    logic [2:0]         w_count_nxt;
    logic [MW-1:0]      r_mix;
    logic [MW-1:0]      w_mix_sum;

    logic               w_key;
    logic               w_owned;
    logic               w_free;
    logic [AW-1:0]      w_own_idx;
    logic [AW-1:0]      w_free_idx;
    logic [AW-1:0]      w_old_idx;
    logic [KW-1:0]      w_old_note;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= keys;
            r_ks    <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= '0;
        end else if (r_scan == C_SCAN_LAST) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + KW'(1);
        end
    end

    assign w_key      = r_ks[r_scan];
    assign w_old_note = r_note[w_old_idx];

    // Descending loop leaves the lowest-numbered free slot selected.
    always_comb begin
        w_owned    = 1'b0;
        w_own_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_old_idx  = '0;
        for (int v = NVOICES - 1; v >= 0; v--) begin
            if (!r_active[v]) begin
                w_free     = 1'b1;
                w_free_idx = AW'(v);
            end
        end
        for (int v = 0; v < NVOICES; v++) begin
            if (r_active[v] && (r_note[v] == r_scan)) begin
                w_owned   = 1'b1;
                w_own_idx = AW'(v);
            end
            if (r_active[v] && (r_age[v] == C_AGE_OLDEST)) begin
                w_old_idx = AW'(v);
            end
        end
    end

    always_comb begin
        w_active_nxt = r_active;
        w_lock_nxt   = r_lock;
        for (int v = 0; v < NVOICES; v++) begin
            w_note_nxt[v] = r_note[v];
            w_age_nxt[v]  = r_age[v];
        end
        if (w_key) begin
            if (!w_owned && !r_lock[r_scan]) begin
                for (int v = 0; v < NVOICES; v++) begin
                    if (r_active[v]) begin
                        w_age_nxt[v] = r_age[v] + AW'(1);
                    end
                end
                if (w_free) begin
                    w_active_nxt[w_free_idx] = 1'b1;
                    w_note_nxt[w_free_idx]   = r_scan;
                    w_age_nxt[w_free_idx]    = '0;
                end else begin
                    // A stolen key that is still held must not re-grab a voice.
                    w_note_nxt[w_old_idx] = r_scan;
                    w_age_nxt[w_old_idx]  = '0;
                    if (r_ks[w_old_note]) begin
                        w_lock_nxt[w_old_note] = 1'b1;
                    end
                end
            end
        end else begin
            w_lock_nxt[r_scan] = 1'b0;
            if (w_owned) begin
                w_active_nxt[w_own_idx] = 1'b0;
                for (int v = 0; v < NVOICES; v++) begin
                    if (r_active[v] && (r_age[v] > r_age[w_own_idx])) begin
                        w_age_nxt[v] = r_age[v] - AW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int v = 0; v < NVOICES; v++) begin
            w_count_nxt = w_count_nxt + {2'b00, w_active_nxt[v]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= '0;
            r_lock   <= '0;
            r_count  <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                r_note[v] <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_active <= w_active_nxt;
            r_lock   <= w_lock_nxt;
            r_count  <= w_count_nxt;
            for (int v = 0; v < NVOICES; v++) begin
                r_note[v] <= w_note_nxt[v];
                r_age[v]  <= w_age_nxt[v];
            end
        end
    end

    always_comb begin
        w_mix_sum = '0;
        for (int v = 0; v < NVOICES; v++) begin
            if (r_active[v] && ({1'b0, r_note[v]} < C_NKEYS)) begin
                w_mix_sum = w_mix_sum + MW'(note_bus[r_note[v]*W +: W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_mix_sum;
        end
    end

    generate
        for (genvar v = 0; v < NVOICES; v++) begin : g_pack
            assign voice_note[v*KW +: KW] = r_note[v];
        end
    endgenerate

    assign voice_active = r_active;
    assign voice_count  = r_count;
    assign mix_out      = r_mix;

endmodule
`default_nettype wire
